// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the word-indexed
// instruction memory (slave); read data is combinational w.r.t. the address.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic        imem_re;
  logic [31:0] imem_data;

  modport master (output imem_addr, output imem_re, input imem_data);
  modport slave  (input imem_addr, input imem_re, output imem_data);
endinterface

// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage: PC, imem request, IF/ID register, drain/halt on zero word.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic [31:0]         branch_target,
  fetch_stage_if.master       imem,
  output logic [31:0]         ifid_instr,
  output logic [31:0]         ifid_pc,
  output logic                ifid_valid,
  output logic                halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_bubbles
`endif
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

  localparam logic [3:0] LP_DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_t      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_ifid_instr, w_ifid_instr_next;
  logic [31:0] r_ifid_pc, w_ifid_pc_next;
  logic        r_ifid_valid, w_ifid_valid_next;
  logic [3:0]  r_drain_cnt, w_drain_cnt_next;
  logic        w_load_valid, w_load_bubble;
  logic [31:0] w_target;

  // Masking keeps every target bit in use while forcing word alignment.
  assign w_target = branch_target & ~32'h3;

  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_ifid_instr_next = r_ifid_instr;
    w_ifid_pc_next    = r_ifid_pc;
    w_ifid_valid_next = r_ifid_valid;
    w_drain_cnt_next  = r_drain_cnt;
    w_load_valid      = 1'b0;
    w_load_bubble     = 1'b0;

    if (flush && r_state != ST_HALT) begin
      w_pc_next         = w_target;
      w_ifid_instr_next = 32'h0;
      w_ifid_pc_next    = 32'h0;
      w_ifid_valid_next = 1'b0;
      w_state_next      = ST_RUN;
      w_load_bubble     = 1'b1;
    end else if (!stall) begin
      case (r_state)
        ST_RUN: begin
          w_ifid_pc_next = r_pc;
          if (imem.imem_data == 32'h0) begin
            w_ifid_instr_next = 32'h0;
            w_ifid_valid_next = 1'b0;
            w_drain_cnt_next  = 4'd0;
            w_state_next      = ST_DRAIN;
            w_load_bubble     = 1'b1;
          end else begin
            w_pc_next         = r_pc + 32'd4;
            w_ifid_instr_next = imem.imem_data;
            w_ifid_valid_next = 1'b1;
            w_load_valid      = 1'b1;
          end
        end
        ST_DRAIN: begin
          w_ifid_instr_next = 32'h0;
          w_ifid_pc_next    = r_pc;
          w_ifid_valid_next = 1'b0;
          w_drain_cnt_next  = r_drain_cnt + 4'd1;
          w_load_bubble     = 1'b1;
          if (r_drain_cnt == LP_DRAIN_LAST) begin
            w_state_next = ST_HALT;
          end
        end
        default: begin
          w_state_next = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_ifid_instr <= 32'h0;
      r_ifid_pc    <= 32'h0;
      r_ifid_valid <= 1'b0;
      r_drain_cnt  <= 4'd0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_ifid_instr <= w_ifid_instr_next;
      r_ifid_pc    <= w_ifid_pc_next;
      r_ifid_valid <= w_ifid_valid_next;
      r_drain_cnt  <= w_drain_cnt_next;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched, r_perf_bubbles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetched <= 32'h0;
      r_perf_bubbles <= 32'h0;
    end else begin
      if (w_load_valid)  r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_load_bubble) r_perf_bubbles <= r_perf_bubbles + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_bubbles = r_perf_bubbles;
`else
  logic w_perf_unused;
  assign w_perf_unused = w_load_valid ^ w_load_bubble;
`endif

  assign imem.imem_addr = {2'b00, r_pc[31:2]};
  assign imem.imem_re   = (r_state == ST_RUN) && !reset;
  assign ifid_instr     = r_ifid_instr;
  assign ifid_pc        = r_ifid_pc;
  assign ifid_valid     = r_ifid_valid;
  assign halted         = (r_state == ST_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage with a scoreboard queue; word 18 of the
// memory model is the zero end-of-program marker, every other word is nonzero.
module tb_fetch_stage;

  typedef struct {
    bit          rst;
    bit          stl;
    bit          fl;
    logic [31:0] tgt;
    logic [31:0] addr;
    bit          re;
    logic [31:0] instr;
    logic [31:0] pc;
    bit          valid;
    bit          hlt;
    bit          payload;
    int          tag;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] branch_target;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
  logic [31:0] bub_snap;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[$];
  vec_t sb[$];

  fetch_stage_if bus ();

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == 32'd18) ? 32'h0 : (32'hA500_0000 + a);
  endfunction

  assign bus.imem_data = word(bus.imem_addr);

  fetch_stage #(.RESET_PC(32'h0), .DRAIN_CYCLES(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .imem          (bus),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_valid    (ifid_valid),
    .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_bubbles  (perf_bubbles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit rst, input bit stl, input bit fl, input logic [31:0] tgt,
                              input logic [31:0] addr, input bit re, input logic [31:0] instr,
                              input logic [31:0] pc, input bit valid, input bit hlt,
                              input bit payload, input int tag);
    vec_t v;
    v.rst = rst; v.stl = stl; v.fl = fl; v.tgt = tgt;
    v.addr = addr; v.re = re; v.instr = instr; v.pc = pc;
    v.valid = valid; v.hlt = hlt; v.payload = payload; v.tag = tag;
    return v;
  endfunction

  initial begin
    vec_t e;
    int   re_low;
    int   halt_cnt;
    bit   seen_halt;

    reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = 32'h0;

    //                rst stl fl tgt            addr           re instr                   pc             v  h  pay tag
    vecs.push_back(mk(1, 0, 0, 32'h0,         32'd0,         0, 32'h0,                  32'h0,         0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'd1,         1, word(0),                32'h0,         1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'd2,         1, word(1),                32'h4,         1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         32'd2,         1, word(1),                32'h4,         1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         32'd2,         1, word(1),                32'h4,         1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'd3,         1, word(2),                32'h8,         1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'd4,         1, word(3),                32'hC,         1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h5A,        32'd22,        1, 32'h0,                  32'h0,         0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'd23,        1, word(22),               32'h58,        1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 32'h40,        32'd16,        1, 32'h0,                  32'h0,         0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'd17,        1, word(16),               32'h40,        1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'd18,        1, word(17),               32'h44,        1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'd18,        0, 32'h0,                  32'h0,         0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'd18,        0, 32'h0,                  32'h0,         0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'd18,        0, 32'h0,                  32'h0,         0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'd18,        0, 32'h0,                  32'h0,         0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0,         32'd18,        0, 32'h0,                  32'h0,         0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         32'd18,        0, 32'h0,                  32'h0,         0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         32'd0,         0, 32'h0,                  32'h0,         0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'd1,         1, word(0),                32'h0,         1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h44,        32'd17,        1, 32'h0,                  32'h0,         0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'd18,        1, word(17),               32'h44,        1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'd18,        0, 32'h0,                  32'h0,         0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h58,        32'd22,        1, 32'h0,                  32'h0,         0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'd23,        1, word(22),               32'h58,        1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFF, 32'h3FFF_FFFF, 1, 32'h0,                  32'h0,         0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'd0,         1, word(32'h3FFF_FFFF),    32'hFFFF_FFFC, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'd1,         1, word(0),                32'h0,         1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,         32'd0,         0, 32'h0,                  32'h0,         0, 0, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; stall = vecs[i].stl; flush = vecs[i].fl; branch_target = vecs[i].tgt;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d.imem_addr", i), bus.imem_addr, e.addr);
      chk($sformatf("v%0d.imem_re", i), {31'h0, bus.imem_re}, {31'h0, e.re});
      chk($sformatf("v%0d.ifid_valid", i), {31'h0, ifid_valid}, {31'h0, e.valid});
      chk($sformatf("v%0d.halted", i), {31'h0, halted}, {31'h0, e.hlt});
      if (e.payload) begin
        chk($sformatf("v%0d.ifid_instr", i), ifid_instr, e.instr);
        chk($sformatf("v%0d.ifid_pc", i), ifid_pc, e.pc);
      end
`ifdef FETCH_PERF_CNT_EN
      if (e.tag == 1) bub_snap = perf_bubbles;
      if (e.tag == 2) chk("perf_bubbles_flush_in_drain", perf_bubbles - bub_snap, 32'd2);
`endif
      $display("vec %0d: rst=%0b stall=%0b flush=%0b addr=0x%08h re=%0b ifid_pc=0x%08h valid=%0b halted=%0b",
               i, e.rst, e.stl, e.fl, bus.imem_addr, bus.imem_re, ifid_pc, ifid_valid, halted);
    end

    // Hand-written sequence: count drain cycles, then HALT must ignore flush/stall.
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; flush = 1'b1; branch_target = 32'h44;
    @(posedge clk);
    #1;
    @(negedge clk);
    flush = 1'b0;
    re_low = 0;
    seen_halt = 1'b0;
    for (int c = 0; c < 20 && !seen_halt; c++) begin
      @(posedge clk);
      #1;
      if (halted) seen_halt = 1'b1;
      else if (!bus.imem_re) re_low++;
    end
    chk("halt_reached", {31'h0, seen_halt}, 32'd1);
    chk("drain_re_low_cycles", re_low, 32'd3);
    $display("drain seq: re_low_cycles=%0d halted=%0b", re_low, halted);

    halt_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      flush = c[0]; stall = c[1]; branch_target = 32'h10;
      @(posedge clk);
      #1;
      if (halted && !bus.imem_re && bus.imem_addr == 32'd18) halt_cnt++;
    end
    chk("halt_sticky", halt_cnt, 32'd5);
    $display("halt seq: sticky_cycles=%0d", halt_cnt);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched_drain_seq", perf_fetched, 32'd1);
    chk("perf_bubbles_drain_seq", perf_bubbles, 32'd5);
`endif

    @(negedge clk);
    reset = 1'b1; flush = 1'b0; stall = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_from_halt.halted", {31'h0, halted}, 32'd0);
    chk("reset_from_halt.imem_addr", bus.imem_addr, 32'd0);
    $display("reset from halt: halted=%0b addr=0x%08h", halted, bus.imem_addr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
